pipe_deserializer: RTL

// - Receiving end of the fixed-latency byte pipe: consumes the pipe's o_data/o_valid beat stream.
// - Packs RATIO consecutive valid beats into one word and queues the word in a small FIFO.
// - Presents queued words downstream with a valid/ready handshake.
// - The source has no backpressure: words arriving at a full FIFO are dropped and counted.

---
 rtl/pipe_deserializer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipe_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_deserializer
// Description : Receive side of the fixed-latency byte pipe. Packs RATIO valid
//               beats into one word (first beat in the LSBs) and queues the
//               word in a DEPTH-entry FIFO presented with valid/ready. Words
//               that reach a full FIFO are dropped and counted, because the
//               source has no backpressure.
//               Optional feature macro: PIPE_DESER_XOR_EN adds o_xor, the XOR
//               of all beats of the head word, stored per FIFO entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_deserializer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_valid,
    input  logic                     i_flush,
    output logic [WIDTH*RATIO-1:0]   o_word,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic                     o_overflow,
    output logic [15:0]              o_drop_cnt,
`ifdef PIPE_DESER_XOR_EN
    output logic [WIDTH-1:0]         o_xor,
`endif
    output logic [$clog2(RATIO)-1:0] o_beat_idx
);
    localparam int IW = $clog2(RATIO);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = WIDTH * RATIO;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'd0,
        S_FILL   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   beat_idx_q, beat_idx_d;
    logic [WW-1:0]   asm_q, asm_d;
    logic [WW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            overflow_q;
    logic [15:0]     drop_cnt_q;
    logic            w_commit, w_pop, w_push, w_drop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A word sitting in COMMIT is pushed unless the FIFO stays full this cycle;
    // a same-cycle pop frees the slot, so push+pop at full is lossless.
    assign w_commit = (state_q == S_COMMIT);
    assign w_pop    = (count_q != '0) & i_ready;
    assign w_push   = w_commit & ((count_q < CW'(DEPTH)) | w_pop);
    assign w_drop   = w_commit & ~w_push;

    // Assembly FSM next state: flush beats any valid beat in the same cycle.
    always_comb begin
        state_d    = state_q;
        beat_idx_d = beat_idx_q;
        asm_d      = asm_q;
        if (i_flush) begin
            state_d    = S_EMPTY;
            beat_idx_d = '0;
        end else if (i_valid) begin
            asm_d[int'(beat_idx_q)*WIDTH +: WIDTH] = i_data;
            if (beat_idx_q == IW'(RATIO - 1)) begin
                state_d    = S_COMMIT;
                beat_idx_d = '0;
            end else begin
                state_d    = S_FILL;
                beat_idx_d = beat_idx_q + IW'(1);
            end
        end else if (state_q == S_COMMIT) begin
            state_d = S_EMPTY;
        end
    end

    // Assembly FSM and packing registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_EMPTY;
            beat_idx_q <= '0;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_idx_q <= beat_idx_d;
            asm_q      <= asm_d;
        end
    end

    // Word FIFO: storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= asm_q;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (w_push && !w_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!w_push && w_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Drop accounting: sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (w_drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

`ifdef PIPE_DESER_XOR_EN
    logic [WIDTH-1:0] xmem_q [DEPTH];
    logic [WIDTH-1:0] w_asm_xor;

    // Fold all beats of the assembled word into one checksum beat.
    always_comb begin
        w_asm_xor = '0;
        for (int k = 0; k < RATIO; k++) begin
            w_asm_xor = w_asm_xor ^ asm_q[k*WIDTH +: WIDTH];
        end
    end

    // Checksum storage travels alongside each FIFO entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                xmem_q[i] <= '0;
            end
        end else if (w_push) begin
            xmem_q[wr_ptr_q] <= w_asm_xor;
        end
    end

    assign o_xor = xmem_q[rd_ptr_q];
`endif

    assign o_word     = mem_q[rd_ptr_q];
    assign o_valid    = (count_q != '0);
    assign o_overflow = overflow_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_beat_idx = beat_idx_q;

endmodule
`default_nettype wire
